reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with in-order commit and branch flush
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic [31:0]              issue_pred_pc,

    output logic [ROB_WIDTH_BIT-1:0] tail_id,
    output logic                     full,

    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,

    input  logic [ROB_WIDTH_BIT-1:0] query1_id,
    input  logic [ROB_WIDTH_BIT-1:0] query2_id,
    output logic                     query1_ready,
    output logic [31:0]              query1_value,
    output logic                     query2_ready,
    output logic [31:0]              query2_value,

    output logic                     commit_valid,
    output logic [1:0]               commit_type,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic                     store_commit,
    output logic                     clear,
    output logic [31:0]              clear_pc
);

    localparam int                     ROB_SIZE    = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] SIZE_CNT    = (ROB_WIDTH_BIT + 1)'(ROB_SIZE);
    localparam logic [1:0]             TYPE_STORE  = 2'd1;
    localparam logic [1:0]             TYPE_BRANCH = 2'd2;

    logic [ROB_SIZE-1:0]      busy;
    logic [ROB_SIZE-1:0]      ready;
    logic [1:0]               ent_type    [ROB_SIZE];
    logic [4:0]               ent_rd      [ROB_SIZE];
    logic [31:0]              ent_pred_pc [ROB_SIZE];
    logic [31:0]              ent_value   [ROB_SIZE];

    logic [ROB_WIDTH_BIT-1:0] head;
    logic [ROB_WIDTH_BIT-1:0] tail;
    logic [ROB_WIDTH_BIT:0]   count;
    logic [ROB_WIDTH_BIT:0]   count_next;

    logic                     do_commit;
    logic                     mispredict;
    logic                     do_issue;

    assign tail_id = tail;

    // Commit uses the registered ready bit, so a result never commits on its writeback edge.
    // A mispredict flush discards any issue on the same edge; a full buffer refuses issue.
    always_comb begin
        do_commit  = rdy_in && busy[head] && ready[head];
        mispredict = do_commit && (ent_type[head] == TYPE_BRANCH) &&
                     (ent_value[head] != ent_pred_pc[head]);
        do_issue   = rdy_in && issue_valid && !full && !mispredict;
        count_next = count;
        if (do_issue && !do_commit) begin
            count_next = count + 1'b1;
        end else if (!do_issue && do_commit) begin
            count_next = count - 1'b1;
        end
    end

    // Operand lookup: stored result first, then same-cycle rs bypass, then lsb bypass.
    always_comb begin
        query1_ready = 1'b0;
        query1_value = '0;
        if (ready[query1_id]) begin
            query1_ready = 1'b1;
            query1_value = ent_value[query1_id];
        end else if (rs_ready && (rs_rob_id == query1_id)) begin
            query1_ready = 1'b1;
            query1_value = rs_value;
        end else if (lsb_ready && (lsb_rob_id == query1_id)) begin
            query1_ready = 1'b1;
            query1_value = lsb_value;
        end
    end

    // Second lookup port, same priority as the first.
    always_comb begin
        query2_ready = 1'b0;
        query2_value = '0;
        if (ready[query2_id]) begin
            query2_ready = 1'b1;
            query2_value = ent_value[query2_id];
        end else if (rs_ready && (rs_rob_id == query2_id)) begin
            query2_ready = 1'b1;
            query2_value = rs_value;
        end else if (lsb_ready && (lsb_rob_id == query2_id)) begin
            query2_ready = 1'b1;
            query2_value = lsb_value;
        end
    end

    // Entry payload: results land in busy entries (lsb written last so it wins), issue fills tail.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (rs_ready && busy[rs_rob_id]) begin
                ent_value[rs_rob_id] <= rs_value;
            end
            if (lsb_ready && busy[lsb_rob_id]) begin
                ent_value[lsb_rob_id] <= lsb_value;
            end
            if (do_issue) begin
                ent_type[tail]    <= issue_type;
                ent_rd[tail]      <= issue_rd;
                ent_pred_pc[tail] <= issue_pred_pc;
                ent_value[tail]   <= '0;
            end
        end
    end

    // Busy/ready flags: flush wipes everything; otherwise writeback, commit and issue update.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy  <= '0;
            ready <= '0;
        end else if (rdy_in) begin
            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
            end else begin
                if (rs_ready && busy[rs_rob_id]) begin
                    ready[rs_rob_id] <= 1'b1;
                end
                if (lsb_ready && busy[lsb_rob_id]) begin
                    ready[lsb_rob_id] <= 1'b1;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                end
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                end
            end
        end
    end

    // Pointers, occupancy and the registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            full          <= 1'b0;
            commit_valid  <= 1'b0;
            commit_type   <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            store_commit  <= 1'b0;
            clear         <= 1'b0;
            clear_pc      <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            clear        <= 1'b0;
        end else begin
            commit_valid <= do_commit;
            store_commit <= do_commit && (ent_type[head] == TYPE_STORE);
            clear        <= mispredict;
            if (do_commit) begin
                commit_type   <= ent_type[head];
                commit_rd     <= ent_rd[head];
                commit_value  <= ent_value[head];
                commit_rob_id <= head;
            end
            if (mispredict) begin
                clear_pc <= ent_value[head];
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                full     <= 1'b0;
            end else begin
                if (do_commit) begin
                    head <= head + 1'b1;
                end
                if (do_issue) begin
                    tail <= tail + 1'b1;
                end
                count <= count_next;
                full  <= (count_next == SIZE_CNT);
            end
        end
    end

endmodule
